// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag bit positions, compare codes
// and the compare-result queue entry layout.
package fpu_pkg;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  localparam logic [2:0] CMP_LE = 3'b000;
  localparam logic [2:0] CMP_LT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;

  localparam int CMP_RD_W = 5;

  typedef struct packed {
    logic [CMP_RD_W-1:0] rd;
    logic                cmp;
    logic                invalid;
  } cmp_entry_t;

  function automatic cmp_entry_t mk_entry(
    input logic [CMP_RD_W-1:0] rd,
    input logic                cmp,
    input logic                invalid
  );
    cmp_entry_t e;
    e.rd      = rd;
    e.cmp     = cmp;
    e.invalid = invalid;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO with flush, shared by the FPU
// writeback stages.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage is written only on an accepted push, so idle inputs
  // never disturb queued entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sp_cmp_writeback.sv
// Single-precision compare writeback stage: queues compare results,
// retires them to the integer register file and accrues NV.
module sp_cmp_writeback
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RD_W  = 5,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_flag_cmp,
  input  logic             in_flag_invalid,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_we,
  output logic [RD_W-1:0]  wb_rd,
  output logic [XLEN-1:0]  wb_data,
  input  logic             csr_fflags_we,
  input  logic [4:0]       csr_fflags_wdata,
  output logic [4:0]       fflags,
  output logic [CNT_W-1:0] retired_cnt
);

  // Entry layout {rd, cmp, invalid}, same order as cmp_entry_t.
  localparam int EW = RD_W + 2;

  logic [EW-1:0] wr_entry;
  logic [EW-1:0] hd_entry;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          set_nv;
  logic [4:0]    fflags_d;

  assign wr_entry = {in_rd, in_flag_cmp, in_flag_invalid};
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign wb_valid = ~empty;
  assign pop      = wb_valid & wb_ready;

  sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (hd_entry),
    .full  (full),
    .empty (empty)
  );

  assign wb_rd   = empty ? '0 : hd_entry[EW-1:2];
  assign wb_data = {{(XLEN-1){1'b0}}, ~empty & hd_entry[1]};
  assign wb_we   = wb_valid & (wb_rd != '0);
  assign set_nv  = pop & hd_entry[0];

  // A retiring invalid op wins over a coincident CSR clear of NV.
  always_comb begin
    fflags_d = csr_fflags_we ? csr_fflags_wdata : fflags;
    if (set_nv) fflags_d[FFLAG_NV] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags      <= '0;
      retired_cnt <= '0;
    end else begin
      fflags <= fflags_d;
      if (pop) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sp_cmp_writeback.sv
// Bench for sp_cmp_writeback: vector table, directed corners,
// random traffic against a queue model, counter wrap stream.
module tb_sp_cmp_writeback;

  localparam int RD_W  = 5;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_flag_cmp;
  logic             in_flag_invalid;
  logic [RD_W-1:0]  in_rd;
  logic             flush;
  logic             wb_valid;
  logic             wb_ready;
  logic             wb_we;
  logic [RD_W-1:0]  wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             csr_fflags_we;
  logic [4:0]       csr_fflags_wdata;
  logic [4:0]       fflags;
  logic [CNT_W-1:0] retired_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sp_cmp_writeback #(
    .DEPTH (DEPTH),
    .RD_W  (RD_W),
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_flag_cmp      (in_flag_cmp),
    .in_flag_invalid  (in_flag_invalid),
    .in_rd            (in_rd),
    .flush            (flush),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_we            (wb_we),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .csr_fflags_we    (csr_fflags_we),
    .csr_fflags_wdata (csr_fflags_wdata),
    .fflags           (fflags),
    .retired_cnt      (retired_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic       cmp;
    logic       inv;
    logic [4:0] rd;
    logic       wr;
    logic       fl;
    logic       cwe;
    logic [4:0] cwd;
    logic       e_rdy;
    logic       e_wbv;
    logic [4:0] e_rd;
    logic       e_we;
    logic       e_d;
    logic [4:0] e_ff;
    int         e_cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic v, logic cmp, logic inv, logic [4:0] rd, logic wr,
    logic fl, logic cwe, logic [4:0] cwd,
    logic e_rdy, logic e_wbv, logic [4:0] e_rd, logic e_we,
    logic e_d, logic [4:0] e_ff, int e_cnt);
    vec_t t;
    t.v = v; t.cmp = cmp; t.inv = inv; t.rd = rd; t.wr = wr;
    t.fl = fl; t.cwe = cwe; t.cwd = cwd;
    t.e_rdy = e_rdy; t.e_wbv = e_wbv; t.e_rd = e_rd;
    t.e_we = e_we; t.e_d = e_d; t.e_ff = e_ff; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic idle_inputs();
    in_valid         = 1'b0;
    in_flag_cmp      = 1'b0;
    in_flag_invalid  = 1'b0;
    in_rd            = '0;
    flush            = 1'b0;
    wb_ready         = 1'b0;
    csr_fflags_we    = 1'b0;
    csr_fflags_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  typedef struct {
    logic [4:0] rd;
    logic       cmp;
    logic       inv;
  } ent_t;

  ent_t             mq[$];
  logic [4:0]       m_ff;
  logic [CNT_W-1:0] m_cnt;

  initial begin
    int bubbles;
    ent_t e;
    logic do_pop, do_push;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("async_reset_in_ready", in_ready, 1);
    chk("async_reset_wb_valid", wb_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_wb_we", wb_we, 0);
    chk("reset_wb_rd", wb_rd, 0);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_fflags", fflags, 0);
    chk("reset_cnt", retired_cnt, 0);

    //   v cmp inv rd wr fl cwe cwd | rdy wbv rd we d | ff cnt
    tv.push_back(mk(1,1,0,5, 1,0,0,0, 1,0,0,0,0, 5'h00,0));
    tv.push_back(mk(0,0,0,0, 1,0,0,0, 1,1,5,1,1, 5'h00,1));
    tv.push_back(mk(0,0,0,0, 1,0,0,0, 1,0,0,0,0, 5'h00,1));
    tv.push_back(mk(1,0,0,1, 0,0,0,0, 1,0,0,0,0, 5'h00,1));
    tv.push_back(mk(1,1,0,2, 0,0,0,0, 1,1,1,1,0, 5'h00,1));
    tv.push_back(mk(1,1,0,3, 0,0,0,0, 0,1,1,1,0, 5'h00,1));
    tv.push_back(mk(1,1,0,3, 0,0,0,0, 0,1,1,1,0, 5'h00,1));
    tv.push_back(mk(1,1,0,3, 1,0,0,0, 0,1,1,1,0, 5'h00,2));
    tv.push_back(mk(1,1,0,3, 1,0,0,0, 1,1,2,1,1, 5'h00,3));
    tv.push_back(mk(0,0,0,0, 1,0,0,0, 1,1,3,1,1, 5'h00,4));
    tv.push_back(mk(1,0,1,0, 0,0,0,0, 1,0,0,0,0, 5'h00,4));
    tv.push_back(mk(0,0,0,0, 1,0,0,0, 1,1,0,0,0, 5'h10,5));
    tv.push_back(mk(1,1,1,7, 0,0,0,0, 1,0,0,0,0, 5'h10,5));
    tv.push_back(mk(0,0,0,0, 1,0,1,0, 1,1,7,1,1, 5'h10,6));
    tv.push_back(mk(0,0,0,0, 0,0,1,3, 1,0,0,0,0, 5'h03,6));
    tv.push_back(mk(0,0,0,0, 0,0,1,0, 1,0,0,0,0, 5'h00,6));
    tv.push_back(mk(1,0,1,4, 0,0,0,0, 1,0,0,0,0, 5'h00,6));
    tv.push_back(mk(1,1,1,6, 0,0,0,0, 1,1,4,1,0, 5'h00,6));
    tv.push_back(mk(0,0,0,0, 0,1,0,0, 0,1,4,1,0, 5'h00,6));
    tv.push_back(mk(0,0,0,0, 1,0,0,0, 1,0,0,0,0, 5'h00,6));
    tv.push_back(mk(1,0,1,4, 0,0,0,0, 1,0,0,0,0, 5'h00,6));
    tv.push_back(mk(1,1,0,9, 1,1,0,0, 1,1,4,1,0, 5'h10,7));
    tv.push_back(mk(0,0,0,0, 1,0,0,0, 1,0,0,0,0, 5'h10,7));

    foreach (tv[i]) begin
      in_valid         = tv[i].v;
      in_flag_cmp      = tv[i].cmp;
      in_flag_invalid  = tv[i].inv;
      in_rd            = tv[i].rd;
      wb_ready         = tv[i].wr;
      flush            = tv[i].fl;
      csr_fflags_we    = tv[i].cwe;
      csr_fflags_wdata = tv[i].cwd;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), in_ready, tv[i].e_rdy);
      chk($sformatf("v%0d_wb_valid", i), wb_valid, tv[i].e_wbv);
      chk($sformatf("v%0d_wb_rd", i), wb_rd, tv[i].e_rd);
      chk($sformatf("v%0d_wb_we", i), wb_we, tv[i].e_we);
      chk($sformatf("v%0d_wb_data", i), wb_data,
          {31'b0, tv[i].e_d});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_fflags", i), fflags, tv[i].e_ff);
      chk($sformatf("v%0d_cnt", i), retired_cnt, tv[i].e_cnt);
    end
    idle_inputs();

    // Async reset with two entries queued
    in_valid = 1'b1; in_rd = 5'd11; in_flag_cmp = 1'b1;
    in_flag_invalid = 1'b1;
    repeat (2) @(posedge clk);
    #1 idle_inputs();
    chk("midrst_pre_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_wb_we", wb_we, 0);
    chk("midrst_wb_rd", wb_rd, 0);
    chk("midrst_wb_data", wb_data, 0);
    chk("midrst_fflags", fflags, 0);
    chk("midrst_cnt", retired_cnt, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against queue model
    m_ff  = '0;
    m_cnt = '0;
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid         = ($urandom_range(0, 3) != 0);
      in_rd            = 5'($urandom_range(0, 31));
      in_flag_cmp      = 1'($urandom);
      in_flag_invalid  = ($urandom_range(0, 3) == 0);
      wb_ready         = ($urandom_range(0, 2) != 0);
      flush            = ($urandom_range(0, 19) == 0);
      csr_fflags_we    = ($urandom_range(0, 9) == 0);
      csr_fflags_wdata = 5'($urandom);
      @(negedge clk);
      chk("rnd_in_ready", in_ready, mq.size() < DEPTH);
      chk("rnd_wb_valid", wb_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("rnd_wb_rd", wb_rd, mq[0].rd);
        chk("rnd_wb_data", wb_data, {31'b0, mq[0].cmp});
        chk("rnd_wb_we", wb_we, mq[0].rd != 0);
      end else begin
        chk("rnd_wb_rd_empty", wb_rd, 0);
        chk("rnd_wb_data_empty", wb_data, 0);
        chk("rnd_wb_we_empty", wb_we, 0);
      end
      do_pop  = wb_ready && mq.size() > 0;
      do_push = in_valid && mq.size() < DEPTH;
      m_ff = csr_fflags_we ? csr_fflags_wdata : m_ff;
      if (do_pop) begin
        e = mq.pop_front();
        m_cnt++;
        if (e.inv) m_ff[4] = 1'b1;
      end
      if (flush) mq.delete();
      else if (do_push) begin
        e.rd = in_rd; e.cmp = in_flag_cmp; e.inv = in_flag_invalid;
        mq.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("rnd_fflags", fflags, m_ff);
      chk("rnd_cnt", retired_cnt, m_cnt);
    end

    // Full-throughput stream across the counter wrap
    do_reset();
    bubbles = 0;
    in_valid = 1'b1;
    wb_ready = 1'b1;
    in_rd = 5'd1;
    for (int c = 0; c < (1 << CNT_W) + 3; c++) begin
      @(negedge clk);
      if (c > 0 && !wb_valid) bubbles++;
      if (!in_ready) bubbles++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", wb_valid, 1);
    @(posedge clk);
    #1;
    chk("stream_bubbles", bubbles, 0);
    chk("stream_wrap_cnt", retired_cnt, 3);
    chk("stream_drained", wb_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_cmp_writeback.md
Name: sp_cmp_writeback

Overview:
Downstream stage of the single-precision compare unit. It accepts one compare result per handshake (flag_cmp, flag_invalid, destination register index) into a small FIFO. It retires results toward the integer register-file writeback port over a valid/ready handshake. It accumulates the sticky IEEE invalid (NV) exception flag into the fflags register at retirement, so flushed operations never raise flags.

Parameters:
DEPTH, 2, number of result FIFO entries (power of two, >=2)
RD_W, 5, destination register index width
XLEN, 32, writeback data width
CNT_W, 16, retired-compare counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  compare result presented
in_ready  out  1  stage can accept (FIFO not full)
in_flag_cmp  in  1  compare result bit (EQ/LT/LE outcome)
in_flag_invalid  in  1  signalling-NaN invalid indication
in_rd  in  RD_W  destination integer register
flush  in  1  synchronous discard of all queued results
wb_valid  out  1  head result available
wb_ready  in  1  register file accepts head
wb_we  out  1  write enable (wb_valid and wb_rd != 0)
wb_rd  out  RD_W  head destination register
wb_data  out  XLEN  zero-extended compare bit
csr_fflags_we  in  1  CSR write of fflags
csr_fflags_wdata  in  5  CSR write data {NV,DZ,OF,UF,NX}
fflags  out  5  accrued exception flags
retired_cnt  out  CNT_W  count of retired compares

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, fflags=0, retired_cnt=0. Consequently wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, in_ready=1.
- Entry format: {rd, cmp, invalid}. push = in_valid & in_ready. pop = wb_valid & wb_ready.
- in_ready = !full, combinational from occupancy count only. It never depends on wb_ready, so there is no pass-through when full.
- wb_valid = !empty. wb_rd, wb_data={XLEN-1 zeros, cmp} come from the FIFO head. When empty, wb_rd and wb_data are driven 0.
- Latency: a result pushed at edge N appears on wb_valid after edge N (1 cycle). There is no same-cycle bypass.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. The full/empty distinction uses a count register of width log2(DEPTH)+1.
- wb_rd == 0: the entry still retires on handshake with wb_we=0. Its flag and counter effects still apply.
- Retirement effects on pop: retired_cnt += 1, wrapping at 2^CNT_W. set_nv = head.invalid.
- fflags update each cycle: next = (csr_fflags_we ? csr_fflags_wdata : fflags) | {set_nv,4'b0}. If a CSR write coincides with a retiring invalid op, NV ends up set.
- flush: at the edge, the FIFO is emptied (count=0, pointers=0).
  - A push in the same cycle is discarded.
  - A pop in the same cycle is honoured: the head retires, flags and counter update.
  - fflags and retired_cnt are otherwise unaffected.
- Backpressure: while wb_valid=1 and wb_ready=0, the head and all wb_* outputs hold stable.
- in_* signals are sampled only when push=1. X on in_* while in_valid=0 must not corrupt state.

Decomposition:
- Shared package fpu_pkg holds:
  - FFLAG_NV=4, FFLAG_DZ=3, FFLAG_OF=2, FFLAG_UF=1, FFLAG_NX=0;
  - compare func3 codes CMP_LE=3'b000, CMP_LT=3'b001, CMP_EQ=3'b010;
  - the packed result-entry typedef.
- One sub-module: sync_fifo (parameterised width/depth, count-based full/empty, flush input), reused by other FPU writeback stages.
- Flag accrual and counter logic stay in sp_cmp_writeback.

Test Plan:
- Reset then idle: after rst_n rises, expect in_ready=1, wb_valid=0, fflags=5'b00000, retired_cnt=0. Assert rst_n low mid-operation with 2 queued entries: all outputs go to reset values immediately.
- Push {rd=5,cmp=1,inv=0} with wb_ready=1: next cycle wb_valid=1, wb_rd=5, wb_data=32'h1, wb_we=1. One cycle later wb_valid=0 and retired_cnt=1.
- Hold wb_ready=0 and push 3 results (rd=1,2,3): after 2 pushes in_ready=0 and the third is held off. Release wb_ready: results retire in order 1,2,3 with outputs stable during stall.
- Push {rd=0,cmp=0,inv=1}, retire it: wb_we=0 and fflags=5'b10000. Then CSR write 5'b00000 in the same cycle as retiring another inv=1 entry: fflags=5'b10000.
- Queue 2 entries with inv=1, assert flush with wb_ready=0: FIFO empties, fflags stays 0, retired_cnt unchanged. Repeat with wb_ready=1 and a push in the flush cycle: head retires (NV set, cnt+1) and the pushed entry is dropped.
- Stream 2^CNT_W+3 back-to-back push/pop pairs at full throughput: retired_cnt wraps to 3, and no bubbles appear once the pipeline is filled.
